// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- RISC-V data-memory controller with an internal word-organised
// synchronous RAM.
//
// A request is taken on a valid/ready handshake. The controller latches the
// request, runs one or two RAM access cycles, and then returns a response
// that lasts exactly one cycle. Loads and stores may be byte, half or word
// sized at any byte offset. Out-of-range addresses and illegal funct3 codes
// are answered with an error response. Erroring requests never write the RAM.
//
// Optional feature (compile-time macro DMEM_MISALIGN_EN):
//   defined   : accesses that span two words are split into two sequential
//               RAM accesses. Misaligned accesses that stay inside one word
//               are served in one access.
//   undefined : any access whose offset is not a multiple of its size is an
//               error, and the second-access state is not built.
//
// Parameters:
//   ADDR_W  request byte-address width
//   DEPTH   number of 32-bit words in the array (power of two, >= 2)
//   IDX_W   word-index width (derived)
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   controller can accept a request (IDLE or RESP)
//   req_we_i      1 = store, 0 = load
//   req_funct3_i  000 B, 001 H, 010 W, 100 BU, 101 HU (the last two for loads only)
//   req_addr_i    byte address
//   req_wdata_i   store data, right-justified
//   rsp_valid_o   one-cycle response pulse
//   rsp_rdata_o   extended load data; 0 for stores and errors; held between pulses
//   rsp_err_o     error flag, qualified by rsp_valid_o; held between pulses
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int  ADDR_W = 32,
  parameter int  DEPTH  = 4096,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
`ifdef DMEM_MISALIGN_EN
    ST_ACC2 = 2'd2,
`endif
    ST_RESP = 2'd3
  } state_t;

  // Extend the right-justified load bytes according to funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [2:0]  f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b010:  return raw;
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Byte-lane mask of an access of the given size, before it is shifted by the offset.
  function automatic logic [3:0] size_mask(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  state_t state_q, state_d;

  // Request fields captured on accept
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             err_q;
`ifdef DMEM_MISALIGN_EN
  logic             cross_q;
  logic [31:0]      lo_q;      // first word of a crossing load
  logic             lo_ld;
`endif

  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // RAM
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      rd_word_q;
  logic [IDX_W-1:0] rd_idx;
  logic             mem_we;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, from the request inputs)
  // ---------------------------------------------------------------------------
  logic [1:0]       in_off;
  logic [IDX_W-1:0] in_idx;
  logic [2:0]       in_size;
  logic             in_cross;
  logic             in_err;
  logic             accept;

  always_comb begin
    in_off  = req_addr_i[1:0];
    in_idx  = req_addr_i[IDX_W+1:2];
    case (req_funct3_i[1:0])
      2'b00:   in_size = 3'd1;
      2'b01:   in_size = 3'd2;
      default: in_size = 3'd4;
    endcase
    in_cross = (({1'b0, in_off} + in_size) > 3'd4);

    in_err = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    if (req_we_i && req_funct3_i[2])
      in_err = 1'b1;
    if ((req_addr_i >> (IDX_W + 2)) != '0)
      in_err = 1'b1;
    // No wrap-around from the last word back to word 0.
    if (in_cross && (in_idx == IDX_W'(DEPTH - 1)))
      in_err = 1'b1;
`ifndef DMEM_MISALIGN_EN
    if (((in_size == 3'd2) && in_off[0]) || ((in_size == 3'd4) && (in_off != 2'd0)))
      in_err = 1'b1;
`endif
  end

  assign accept = req_valid_i && req_ready_o;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      off_q   <= in_off;
      idx_q   <= in_idx;
      wdata_q <= req_wdata_i;
      err_q   <= in_err;
`ifdef DMEM_MISALIGN_EN
      cross_q <= in_cross;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Lane steering for the first and (optionally) second word
  // ---------------------------------------------------------------------------
  logic [4:0]  sh_q;
  logic [3:0]  be_base;
  logic [3:0]  be_lo;
  logic [31:0] wd_lo;
  logic [31:0] ld_lo;

  assign sh_q    = {off_q, 3'b000};
  assign be_base = size_mask(f3_q[1:0]);
  assign be_lo   = be_base << off_q;
  assign wd_lo   = wdata_q << sh_q;
  assign ld_lo   = load_extend(rd_word_q >> sh_q, f3_q);

`ifdef DMEM_MISALIGN_EN
  logic [3:0]  be_hi;
  logic [31:0] wd_hi;
  logic [31:0] ld_hi;

  // Bytes that spill past byte 3 go to the low lanes of the next word.
  assign be_hi = 4'(({4'b0000, be_base} << off_q) >> 4);
  assign wd_hi = 32'(({32'h0, wdata_q} << sh_q) >> 32);
  // The first word supplies the low bytes of the result.
  assign ld_hi = load_extend(32'({rd_word_q, lo_q} >> sh_q), f3_q);

  always_ff @(posedge clk) begin
    if (lo_ld)
      lo_q <= rd_word_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // Synchronous RAM: the read is issued on the accept edge, so the word is
  // ready during ACC1. In ACC1 the next word is fetched for ACC2.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_idx = in_idx;
`ifdef DMEM_MISALIGN_EN
    if (state_q == ST_ACC1)
      rd_idx = idx_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    rd_word_q <= mem_q[rd_idx];
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    wr_idx      = idx_q;
    wr_be       = 4'b0000;
    wr_data     = 32'h0;
`ifdef DMEM_MISALIGN_EN
    lo_ld       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (accept)
          state_d = ST_ACC1;
      end

      ST_ACC1: begin
        if (err_q) begin
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          if (we_q) begin
            mem_we  = 1'b1;
            wr_be   = be_lo;
            wr_data = wd_lo;
          end
          state_d     = ST_RESP;
          rsp_rdata_d = we_q ? 32'h0 : ld_lo;
          rsp_err_d   = 1'b0;
`ifdef DMEM_MISALIGN_EN
          if (cross_q) begin
            state_d     = ST_ACC2;
            lo_ld       = !we_q;
            rsp_rdata_d = rsp_rdata_q;
            rsp_err_d   = rsp_err_q;
          end
`endif
        end
      end

`ifdef DMEM_MISALIGN_EN
      ST_ACC2: begin
        if (we_q) begin
          mem_we  = 1'b1;
          wr_idx  = idx_q + 1'b1;
          wr_be   = be_hi;
          wr_data = wd_hi;
        end
        rsp_rdata_d = we_q ? 32'h0 : ld_hi;
        rsp_err_d   = 1'b0;
        state_d     = ST_RESP;
      end
`endif

      ST_RESP: begin
        rsp_valid_o = 1'b1;
        req_ready_o = 1'b1;
        state_d     = accept ? ST_ACC1 : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

`ifdef DMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  localparam int   DEPTH = 64;
  localparam int   XL    = MIS ? 3 : 2;   // latency of a word-crossing access
  localparam logic XE    = !MIS;          // error flag of a word-crossing access

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input string name);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Call at a falling edge. Issues one request and waits for its response.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input string nm);
    int  w;
    int  lat;
    bit  got;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL %s accept: req_ready stayed 0, expected 1", nm);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (lat <= 10) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk({nm, " rsp_seen"}, 32'(got), 32'd1);
    chk({nm, " rdata"}, rsp_rdata, exp_rd);
    chk({nm, " err"}, 32'(rsp_err), 32'(exp_err));
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi, rises, acc, onrsp, k;
    bit          prev;
    logic [31:0] last_exp;

    // Vector table
    add(1, F_W,  32'h08, 32'hDEADBEEF, 32'h0,        0, 2, "SW 08");
    add(0, F_W,  32'h08, 32'h0,        32'hDEADBEEF, 0, 2, "LW 08");
    add(0, F_B,  32'h0B, 32'h0,        32'hFFFFFFDE, 0, 2, "LB 0B");
    add(0, F_BU, 32'h0B, 32'h0,        32'h000000DE, 0, 2, "LBU 0B");
    add(0, F_HU, 32'h0A, 32'h0,        32'h0000DEAD, 0, 2, "LHU 0A");
    add(0, F_B,  32'h08, 32'h0,        32'hFFFFFFEF, 0, 2, "LB 08");
    add(0, F_H,  32'h08, 32'h0,        32'hFFFFBEEF, 0, 2, "LH 08");
    add(0, F_BU, 32'h09, 32'h0,        32'h000000BE, 0, 2, "LBU 09");
    add(1, F_W,  32'h10, 32'h11223344, 32'h0,        0, 2, "SW 10");
    add(1, F_B,  32'h11, 32'h123456AA, 32'h0,        0, 2, "SB 11");
    add(0, F_W,  32'h10, 32'h0,        32'h1122AA44, 0, 2, "LW 10 after SB");
    add(1, F_H,  32'h12, 32'hABCD5566, 32'h0,        0, 2, "SH 12");
    add(0, F_W,  32'h10, 32'h0,        32'h5566AA44, 0, 2, "LW 10 after SH");
    add(0, F_H,  32'h10, 32'h0,        32'hFFFFAA44, 0, 2, "LH 10");
    add(0, F_H,  32'h12, 32'h0,        32'h00005566, 0, 2, "LH 12");
    add(1, F_W,  32'h00, 32'h44332211, 32'h0,        0, 2, "SW 00");
    add(1, F_W,  32'h04, 32'h88776655, 32'h0,        0, 2, "SW 04");
    add(0, F_W,  32'h02, 32'h0, MIS ? 32'h66554433 : 32'h0, XE, XL, "LW 02 cross");
    add(1, F_W,  32'h03, 32'hCAFEBABE, 32'h0,        XE, XL, "SW 03 cross");
    add(0, F_W,  32'h00, 32'h0, MIS ? 32'hBE332211 : 32'h44332211, 0, 2, "LW 00 after SW 03");
    add(0, F_W,  32'h04, 32'h0, MIS ? 32'h88CAFEBA : 32'h88776655, 0, 2, "LW 04 after SW 03");
    add(0, F_W,  32'h01, 32'h0, MIS ? 32'hBABE3322 : 32'h0, XE, XL, "LW 01 cross");
    add(0, F_HU, 32'h03, 32'h0, MIS ? 32'h0000BABE : 32'h0, XE, XL, "LHU 03 cross");
    add(0, F_H,  32'h05, 32'h0, MIS ? 32'hFFFFCAFE : 32'h0, XE, 2, "LH 05 in-word");
    add(1, F_W,  32'hFC, 32'h0BADF00D, 32'h0,        0, 2, "SW FC");
    add(0, F_W,  32'h100, 32'h0,       32'h0,        1, 2, "LW out of range");
    add(0, F_W,  32'h80000008, 32'h0,  32'h0,        1, 2, "LW high addr bit");
    add(1, F_W,  32'h100, 32'h1,       32'h0,        1, 2, "SW out of range");
    add(0, F_H,  32'hFF, 32'h0,        32'h0,        1, 2, "LH last word cross");
    add(1, F_H,  32'hFF, 32'h1234,     32'h0,        1, 2, "SH last word cross");
    add(0, F_W,  32'hFC, 32'h0,        32'h0BADF00D, 0, 2, "LW FC unchanged");
    add(0, 3'b011, 32'h00, 32'h0,      32'h0,        1, 2, "load f3 011");
    add(0, 3'b110, 32'h00, 32'h0,      32'h0,        1, 2, "load f3 110");
    add(0, 3'b111, 32'h00, 32'h0,      32'h0,        1, 2, "load f3 111");
    add(1, F_BU, 32'h08, 32'h0,        32'h0,        1, 2, "store f3 100");
    add(1, F_HU, 32'h08, 32'h0,        32'h0,        1, 2, "store f3 101");
    add(1, F_W,  32'h20, 32'h0,        32'h0,        0, 2, "SW 20");
    add(1, F_H,  32'h07, 32'h00001122, 32'h0,        XE, XL, "SH 07 cross");
    add(0, F_W,  32'h04, 32'h0, MIS ? 32'h22CAFEBA : 32'h88776655, 0, 2, "LW 04 after SH 07");
    add(0, F_W,  32'h08, 32'h0, MIS ? 32'hDEADBE11 : 32'hDEADBEEF, 0, 2, "LW 08 final");

    // Reset state
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #3;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err",   32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors, issued back to back
    last_exp = 32'h0;
    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].name);
      last_exp = vecs[i].exp_rdata;
    end

    // Response data is held between pulses
    repeat (3) @(negedge clk);
    chk("rdata held", rsp_rdata, last_exp);
    chk("rsp_valid idle", 32'(rsp_valid), 32'd0);

    // Asynchronous reset while ACC1 of a store is in progress
    req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset req_ready", 32'(req_ready), 32'd1);
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) hi++;
    end
    chk("no rsp after reset", 32'(hi), 32'd0);
    do_txn(0, F_W, 32'h20, 32'h0, 32'h0, 0, 2, "LW 20 aborted store");

    // Four back-to-back stores with req_valid held high
    @(negedge clk);
    hi = 0; rises = 0; acc = 0; onrsp = 0; k = 0; prev = 1'b0;
    req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h30; req_wdata = 32'hA0A00000;
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) hi++;
      if (rsp_valid && !prev) rises++;
      prev = rsp_valid;
      if (req_valid && req_ready) begin
        acc++;
        if (k > 0 && rsp_valid) onrsp++;
        k++;
      end
      @(posedge clk);
      #1;
      if (k >= 4) begin
        req_valid = 1'b0;
      end else begin
        req_addr  = 32'h30 + 32'(4 * k);
        req_wdata = 32'hA0A00000 | 32'(k);
      end
      @(negedge clk);
    end
    chk("b2b accepts", 32'(acc), 32'd4);
    chk("b2b accept on rsp cycle", 32'(onrsp), 32'd3);
    chk("b2b rsp_valid cycles", 32'(hi), 32'd4);
    chk("b2b rsp_valid pulses", 32'(rises), 32'd4);
    do_txn(0, F_W, 32'h30, 32'h0, 32'hA0A00000, 0, 2, "LW 30 b2b");
    do_txn(0, F_W, 32'h34, 32'h0, 32'hA0A00001, 0, 2, "LW 34 b2b");
    do_txn(0, F_W, 32'h3C, 32'h0, 32'hA0A00003, 0, 2, "LW 3C b2b");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
